// File: rtl/ines_dumper.sv
// iNES image dumper: rebuilds the 16-byte header from the stored mapper flags
// and streams PRG (0x000000) then CHR (0x200000) bytes out of SDRAM.
module ines_dumper (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mapper_flags,
    output logic [21:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_PRG_REQ,
        S_PRG_WAIT,
        S_PRG_OUT,
        S_CHR_REQ,
        S_CHR_WAIT,
        S_CHR_OUT,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic [7:0]  mapper;
    logic [2:0]  prg_size;
    logic [2:0]  chr_size;
    logic        mirroring;
    logic        has_chr_ram;
    logic        four_screen;

    logic [3:0]  idx, idx_n;
    logic [21:0] addr, addr_n;
    logic [21:0] left, left_n;
    logic [7:0]  data_q, data_n;

    logic [21:0] prg_len;
    logic [21:0] chr_len;
    logic [7:0]  prg_pages;
    logic [7:0]  chr_pages;
    logic [7:0]  hdr_byte;

    assign prg_len   = 22'd16384 << prg_size;
    assign chr_len   = has_chr_ram ? 22'd0 : (22'd8192 << chr_size);
    assign prg_pages = 8'd1 << prg_size;
    assign chr_pages = has_chr_ram ? 8'd0 : (8'd1 << chr_size);

    always_comb begin
        hdr_byte = 8'h00;
        unique case (idx)
            4'd0:    hdr_byte = 8'h4E;
            4'd1:    hdr_byte = 8'h45;
            4'd2:    hdr_byte = 8'h53;
            4'd3:    hdr_byte = 8'h1A;
            4'd4:    hdr_byte = prg_pages;
            4'd5:    hdr_byte = chr_pages;
            4'd6:    hdr_byte = {mapper[3:0], four_screen, 2'b00, mirroring};
            4'd7:    hdr_byte = {mapper[7:4], 4'h0};
            default: hdr_byte = 8'h00;
        endcase
    end

    // Flags are captured only on an accepted start so mid-dump changes are inert.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            mapper      <= '0;
            prg_size    <= '0;
            chr_size    <= '0;
            mirroring   <= 1'b0;
            has_chr_ram <= 1'b0;
            four_screen <= 1'b0;
        end else if (state == S_IDLE && start) begin
            mapper      <= mapper_flags[7:0];
            prg_size    <= mapper_flags[10:8];
            chr_size    <= mapper_flags[13:11];
            mirroring   <= mapper_flags[14];
            has_chr_ram <= mapper_flags[15];
            four_screen <= mapper_flags[16];
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            addr   <= '0;
            left   <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            addr   <= addr_n;
            left   <= left_n;
            data_q <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        addr_n  = addr;
        left_n  = left;
        data_n  = data_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_HDR;
                    idx_n   = 4'd0;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    idx_n = idx + 4'd1;
                    if (idx == 4'd15) begin
                        state_n = S_PRG_REQ;
                        addr_n  = 22'd0;
                        left_n  = prg_len;
                    end
                end
            end
            S_PRG_REQ: state_n = S_PRG_WAIT;
            S_PRG_WAIT: begin
                if (mem_ack) begin
                    data_n  = mem_din;
                    state_n = S_PRG_OUT;
                end
            end
            S_PRG_OUT: begin
                if (out_ready) begin
                    addr_n  = addr + 22'd1;
                    left_n  = left - 22'd1;
                    state_n = S_PRG_REQ;
                    if (left == 22'd1) begin
                        if (chr_len != 22'd0) begin
                            state_n = S_CHR_REQ;
                            addr_n  = 22'h200000;
                            left_n  = chr_len;
                        end else begin
                            state_n = S_FIN;
                        end
                    end
                end
            end
            S_CHR_REQ: state_n = S_CHR_WAIT;
            S_CHR_WAIT: begin
                if (mem_ack) begin
                    data_n  = mem_din;
                    state_n = S_CHR_OUT;
                end
            end
            S_CHR_OUT: begin
                if (out_ready) begin
                    addr_n  = addr + 22'd1;
                    left_n  = left - 22'd1;
                    state_n = (left == 22'd1) ? S_FIN : S_CHR_REQ;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign mem_addr  = addr;
    assign mem_rd    = (state == S_PRG_REQ) || (state == S_CHR_REQ);
    assign out_valid = (state == S_HDR) || (state == S_PRG_OUT) ||
                       (state == S_CHR_OUT);
    assign out_data  = (state == S_HDR) ? hdr_byte : data_q;
    // FIN is the closing pulse, so busy is already released there.
    assign busy      = (state != S_IDLE) && (state != S_FIN);
    assign done      = (state == S_FIN);

endmodule
